// File: rtl/ex_pkg.sv
// Shared types for the execute stage: operation codes, multiply/divide
// FSM states and small op-class helpers.
package ex_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLT   = 4'd5,
      OP_SLTU  = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_MFHI  = 4'd10,
      OP_MFLO  = 4'd11,
      OP_MULT  = 4'd12,
      OP_MULTU = 4'd13,
      OP_DIV   = 4'd14,
      OP_DIVU  = 4'd15
   } op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // Multi-cycle multiply/divide operations (write HI/LO, not the result bus).
   function automatic logic is_md_op(input logic [3:0] op);
      logic r;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      logic r;
      case (op)
         OP_DIV, OP_DIVU: r = 1'b1;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

   // Operations that treat their operands as two's complement.
   function automatic logic is_signed_md(input logic [3:0] op);
      logic r;
      case (op)
         OP_MULT, OP_DIV: r = 1'b1;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: one shift-add (multiply) or restoring
// subtract (divide) step per cycle on operand magnitudes, DW steps total,
// with sign correction and the divide corner cases applied on the last step.
// Handshake: i_start in IDLE launches, o_busy while iterating, o_done pulses
// for one cycle together with valid o_hi/o_lo.
module ex_muldiv
   import ex_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [3:0]    i_op,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic          o_busy,
   output logic          o_done,
   output logic [DW-1:0] o_hi,
   output logic [DW-1:0] o_lo
);

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   md_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*DW-1:0]   p_q, p_d;       // {remainder/product-high, quotient/multiplier}
   logic [DW-1:0]     b_q, b_d;       // divisor or multiplicand magnitude
   logic [DW-1:0]     dvd_q, dvd_d;   // raw dividend for the divide-by-zero result
   logic              div_q, div_d;
   logic              negq_q, negq_d; // negate product / quotient
   logic              negr_q, negr_d; // negate remainder
   logic              dz_q, dz_d;

   logic              a_neg_s, b_neg_s;
   logic [DW-1:0]     a_mag_s, b_mag_s;
   logic [DW:0]       mul_sum_s, div_r_s, div_diff_s;
   logic [2*DW-1:0]   p_step_s, prod_s;
   logic [DW-1:0]     quo_s, rem_s;

   assign o_busy = (state_q == MD_BUSY);

   // Operand magnitudes and signs captured at start.
   always_comb begin
      a_neg_s = is_signed_md(i_op) & i_a[DW-1];
      b_neg_s = is_signed_md(i_op) & i_b[DW-1];
      a_mag_s = a_neg_s ? ({DW{1'b0}} - i_a) : i_a;
      b_mag_s = b_neg_s ? ({DW{1'b0}} - i_b) : i_b;
   end

   // One iteration step of the selected algorithm.
   always_comb begin
      mul_sum_s  = {1'b0, p_q[2*DW-1:DW]} + (p_q[0] ? {1'b0, b_q} : {(DW+1){1'b0}});
      div_r_s    = p_q[2*DW-1:DW-1];
      div_diff_s = div_r_s - {1'b0, b_q};
      if (div_q) begin
         if (!div_diff_s[DW]) begin
            p_step_s = {div_diff_s[DW-1:0], p_q[DW-2:0], 1'b1};
         end else begin
            p_step_s = {div_r_s[DW-1:0], p_q[DW-2:0], 1'b0};
         end
      end else begin
         p_step_s = {mul_sum_s, p_q[DW-1:1]};
      end
   end

   // Final HI/LO from the last step, with sign fix-up and divide-by-zero.
   always_comb begin
      prod_s = negq_q ? ({(2*DW){1'b0}} - p_step_s) : p_step_s;
      quo_s  = p_step_s[DW-1:0];
      rem_s  = p_step_s[2*DW-1:DW];
      if (!div_q) begin
         o_hi = prod_s[2*DW-1:DW];
         o_lo = prod_s[DW-1:0];
      end else if (dz_q) begin
         o_hi = dvd_q;
         o_lo = {DW{1'b1}};
      end else begin
         o_hi = negr_q ? ({DW{1'b0}} - rem_s) : rem_s;
         o_lo = negq_q ? ({DW{1'b0}} - quo_s) : quo_s;
      end
   end

   // FSM next state: launch on start, iterate exactly DW cycles, then finish.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      b_d     = b_q;
      dvd_d   = dvd_q;
      div_d   = div_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      o_done  = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (i_start) begin
               state_d = MD_BUSY;
               cnt_d   = {CW{1'b0}};
               p_d     = {{DW{1'b0}}, a_mag_s};
               b_d     = b_mag_s;
               dvd_d   = i_a;
               div_d   = is_div_op(i_op);
               negq_d  = a_neg_s ^ b_neg_s;
               negr_d  = a_neg_s;
               dz_d    = (i_b == {DW{1'b0}});
            end else begin
               state_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            p_d = p_step_s;
            if (cnt_q == CNT_LAST) begin
               state_d = MD_IDLE;
               cnt_d   = {CW{1'b0}};
               o_done  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= {CW{1'b0}};
         p_q     <= {(2*DW){1'b0}};
         b_q     <= {DW{1'b0}};
         dvd_q   <= {DW{1'b0}};
         div_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         b_q     <= b_d;
         dvd_q   <= dvd_d;
         div_q   <= div_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU with registered
// results, and an optional iterative multiply/divide unit with HI/LO.
// Define EX_STAGE_MD_EN to enable multiply/divide and HI/LO; otherwise
// MD ops and MFHI/MFLO complete in one cycle with a zero result.
module ex_stage_md
   import ex_pkg::*;
#(
   parameter int DW   = 32,
   parameter int NFWD = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_stall,
   input  logic [3:0]        i_op,
   input  logic [DW-1:0]     i_data_rs,
   input  logic [DW-1:0]     i_data_rt,
   input  logic [DW-1:0]     i_data_imm,
   input  logic              i_con_imm,
   input  logic [4:0]        i_addr_rs,
   input  logic [4:0]        i_addr_rt,
   input  logic [4:0]        i_addr_dst,
   input  logic [NFWD*DW-1:0] i_fwd_data,
   input  logic [NFWD*5-1:0] i_fwd_addr,
   input  logic [NFWD-1:0]   i_fwd_we,
   output logic              o_valid,
   output logic [DW-1:0]     o_data_alures,
   output logic [DW-1:0]     o_data_rt,
   output logic [4:0]        o_addr_regdst
);

   localparam int SW = $clog2(DW);

   logic [DW-1:0] rs_fwd_s, rt_fwd_s, op_b_s, alu_s, hi_s, lo_s;
   logic [DW-1:0] md_hi_s, md_lo_s;
   logic          accept_s, md_start_s, md_busy_s, md_done_s;
   logic          valid_q, valid_d;
   logic [DW-1:0] res_q, res_d, rt_q, rt_d;
   logic [4:0]    dst_q, dst_d;

   // Lowest-numbered enabled source with a matching non-zero address wins.
   function automatic logic [DW-1:0] fwd_pick(input logic [4:0] addr,
                                              input logic [DW-1:0] rf,
                                              input logic [NFWD*DW-1:0] fdata,
                                              input logic [NFWD*5-1:0] faddr,
                                              input logic [NFWD-1:0] fwe);
      logic [DW-1:0] v;
      v = rf;
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (fwe[k] && (faddr[k*5 +: 5] == addr) && (addr != 5'd0)) begin
            v = fdata[k*DW +: DW];
         end
      end
      return v;
   endfunction

`ifdef EX_STAGE_MD_EN
   localparam logic MD_EN = 1'b1;
   logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;

   // HI/LO take the unit's result only in the cycle it finishes.
   always_comb begin
      if (md_done_s) begin
         hi_d = md_hi_s;
         lo_d = md_lo_s;
      end else begin
         hi_d = hi_q;
         lo_d = lo_q;
      end
   end

   // HI/LO storage.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hi_q <= {DW{1'b0}};
         lo_q <= {DW{1'b0}};
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_s = hi_q;
   assign lo_s = lo_q;
`else
   localparam logic MD_EN = 1'b0;
   logic md_unused_s;
   assign md_unused_s = ^{md_done_s, md_hi_s, md_lo_s};
   assign hi_s = {DW{1'b0}};
   assign lo_s = {DW{1'b0}};
`endif

   assign o_ready    = !i_stall && !md_busy_s;
   assign accept_s   = i_valid && o_ready;
   assign md_start_s = accept_s && MD_EN && is_md_op(i_op);

   ex_muldiv #(.DW(DW)) u_muldiv (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (md_start_s),
      .i_op    (i_op),
      .i_a     (rs_fwd_s),
      .i_b     (op_b_s),
      .o_busy  (md_busy_s),
      .o_done  (md_done_s),
      .o_hi    (md_hi_s),
      .o_lo    (md_lo_s)
   );

   // Operand selection: forwarding, then immediate substitution for B.
   always_comb begin
      rs_fwd_s = fwd_pick(i_addr_rs, i_data_rs, i_fwd_data, i_fwd_addr, i_fwd_we);
      rt_fwd_s = fwd_pick(i_addr_rt, i_data_rt, i_fwd_data, i_fwd_addr, i_fwd_we);
      op_b_s   = i_con_imm ? i_data_imm : rt_fwd_s;
   end

   // Single-cycle ALU; MD ops produce zero on the result bus.
   always_comb begin
      case (i_op)
         OP_ADD:  alu_s = rs_fwd_s + op_b_s;
         OP_SUB:  alu_s = rs_fwd_s - op_b_s;
         OP_AND:  alu_s = rs_fwd_s & op_b_s;
         OP_OR:   alu_s = rs_fwd_s | op_b_s;
         OP_XOR:  alu_s = rs_fwd_s ^ op_b_s;
         OP_SLT:  alu_s = {{(DW-1){1'b0}}, ($signed(rs_fwd_s) < $signed(op_b_s))};
         OP_SLTU: alu_s = {{(DW-1){1'b0}}, (rs_fwd_s < op_b_s)};
         OP_SLL:  alu_s = rs_fwd_s << op_b_s[SW-1:0];
         OP_SRL:  alu_s = rs_fwd_s >> op_b_s[SW-1:0];
         OP_SRA:  alu_s = $signed(rs_fwd_s) >>> op_b_s[SW-1:0];
         OP_MFHI: alu_s = hi_s;
         OP_MFLO: alu_s = lo_s;
         default: alu_s = {DW{1'b0}};
      endcase
   end

   // Output register control: hold on stall, load on accepted single-cycle op.
   always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      rt_d    = rt_q;
      dst_d   = dst_q;
      if (i_stall) begin
         valid_d = valid_q;
      end else if (accept_s && !md_start_s) begin
         valid_d = 1'b1;
         res_d   = alu_s;
         rt_d    = rt_fwd_s;
         dst_d   = i_addr_dst;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Registered stage outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         res_q   <= {DW{1'b0}};
         rt_q    <= {DW{1'b0}};
         dst_q   <= 5'd0;
      end else begin
         valid_q <= valid_d;
         res_q   <= res_d;
         rt_q    <= rt_d;
         dst_q   <= dst_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_data_alures = res_q;
   assign o_data_rt     = rt_q;
   assign o_addr_regdst = dst_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_ex_stage_md;
   import ex_pkg::*;

   localparam int DW   = 32;
   localparam int NFWD = 2;
`ifdef EX_STAGE_MD_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic              clk, rst, valid, stall, con_imm;
   logic [3:0]        op;
   logic [DW-1:0]     drs, drt, dimm;
   logic [4:0]        ars, art, adst;
   logic [NFWD*DW-1:0] fwd_data;
   logic [NFWD*5-1:0] fwd_addr;
   logic [NFWD-1:0]   fwd_we;
   logic              o_ready, o_valid;
   logic [DW-1:0]     o_res, o_rt;
   logic [4:0]        o_dst;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic          m_valid;
   logic [DW-1:0] m_res, m_rt, m_hi, m_lo, m_phi, m_plo;
   logic [4:0]    m_dst;
   int            m_busy;
   logic          last_ready;

   ex_stage_md #(.DW(DW), .NFWD(NFWD)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_stall(stall),
      .i_op(op), .i_data_rs(drs), .i_data_rt(drt), .i_data_imm(dimm), .i_con_imm(con_imm),
      .i_addr_rs(ars), .i_addr_rt(art), .i_addr_dst(adst),
      .i_fwd_data(fwd_data), .i_fwd_addr(fwd_addr), .i_fwd_we(fwd_we),
      .o_valid(o_valid), .o_data_alures(o_res), .o_data_rt(o_rt), .o_addr_regdst(o_dst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
      for (int k = 0; k < NFWD; k++) begin
         if (fwd_we[k] && addr != 5'd0 && fwd_addr[k*5 +: 5] == addr) return fwd_data[k*32 +: 32];
      end
      return rf;
   endfunction

   function automatic logic is_md(input logic [3:0] o);
      return o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (o)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
         OP_SLL:  return 32'(longint'({32'd0, a}) * (longint'(1) << sh));
         OP_SRL:  return 32'(longint'({32'd0, a}) / (longint'(1) << sh));
         OP_SRA:  return 32'(int'(a) >>> sh);
         OP_MFHI: return MD_EN ? m_hi : 32'd0;
         OP_MFLO: return MD_EN ? m_lo : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic ref_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int     q, r;
      case (o)
         OP_MULT: begin
            p = longint'(int'(a)) * longint'(int'(b));
            m_phi = p[63:32]; m_plo = p[31:0];
         end
         OP_MULTU: begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            m_phi = p[63:32]; m_plo = p[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               m_plo = 32'hFFFF_FFFF; m_phi = a;
            end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               m_plo = 32'h8000_0000; m_phi = 32'd0;
            end else if (o == OP_DIV) begin
               q = int'(a) / int'(b); r = int'(a) % int'(b);
               m_plo = q; m_phi = r;
            end else begin
               m_plo = a / b; m_phi = a % b;
            end
         end
      endcase
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_res = 32'd0; m_rt = 32'd0; m_dst = 5'd0;
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 0;
   endtask

   // One clock cycle with the current inputs; checks ready before the edge
   // and all registered outputs after it.
   task automatic cycle();
      logic [31:0] a, rtv, b;
      logic        exp_ready, acc;
      #1;
      exp_ready = !stall && (m_busy == 0);
      last_ready = o_ready;
      chk("ready", {31'd0, o_ready}, {31'd0, exp_ready});
      acc = valid && exp_ready;
      a   = ref_fwd(ars, drs);
      rtv = ref_fwd(art, drt);
      b   = con_imm ? dimm : rtv;
      @(posedge clk);
      #1;
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin m_hi = m_phi; m_lo = m_plo; end
      end
      if (!stall) begin
         if (acc && MD_EN && is_md(op)) begin
            m_busy = DW; ref_md(op, a, b); m_valid = 1'b0;
         end else if (acc) begin
            m_valid = 1'b1; m_res = ref_alu(op, a, b); m_rt = rtv; m_dst = adst;
         end else begin
            m_valid = 1'b0;
         end
      end
      chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
      chk("alures", o_res, m_res);
      chk("data_rt", o_rt, m_rt);
      chk("regdst", {27'd0, o_dst}, {27'd0, m_dst});
   endtask

   task automatic idle();
      valid = 1'b0; stall = 1'b0; con_imm = 1'b0; fwd_we = '0;
   endtask

   task automatic set_op(input logic [3:0] o, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_dst);
      valid = 1'b1; op = o; drs = rs; drt = rt; ars = a_rs; art = a_rt; adst = a_dst;
      con_imm = 1'b0; dimm = 32'd0;
   endtask

   // Count cycles until the stage is ready again (bounded).
   task automatic wait_ready(output int n);
      valid = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (last_ready) break;
         n++;
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      logic [31:0] held;
      clk = 1'b0; rst = 1'b0; op = 4'd0; drs = 32'd0; drt = 32'd0; dimm = 32'd0;
      ars = 5'd0; art = 5'd0; adst = 5'd0; fwd_data = '0; fwd_addr = '0;
      idle();
      model_reset();
      #1 rst = 1'b1;
      #2;
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_alures", o_res, 32'd0);
      chk("reset_ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk); #1 rst = 1'b0;

      // forward source 0 onto rs: 100 + 7
      set_op(OP_ADD, 32'd5, 32'd7, 5'd3, 5'd4, 5'd9);
      fwd_we = 2'b01; fwd_addr = {5'd0, 5'd3}; fwd_data = {32'd0, 32'd100};
      cycle();
      chk("fwd_add", o_res, 32'd107);
      chk("fwd_add_valid", {31'd0, o_valid}, 32'd1);

      // both sources match rt: lowest index wins, 10 - 3
      set_op(OP_SUB, 32'd10, 32'd55, 5'd2, 5'd5, 5'd6);
      fwd_we = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'd9, 32'd3};
      cycle();
      chk("fwd_prio", o_res, 32'd7);

      // address 0 never forwards
      set_op(OP_SUB, 32'd10, 32'd3, 5'd0, 5'd0, 5'd6);
      fwd_we = 2'b11; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'd40, 32'd50};
      cycle();
      chk("fwd_zero", o_res, 32'd7);
      idle();

      // DIV -7 / 2, then read LO and HI
      set_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 5'd2, 5'd3);
      cycle();
      wait_ready(n);
      chk("div_busy_cycles", 32'(n), MD_EN ? 32'd32 : 32'd0);
      set_op(OP_MFLO, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("div_lo", o_res, MD_EN ? 32'hFFFF_FFFD : 32'd0);
      set_op(OP_MFHI, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("div_hi", o_res, MD_EN ? 32'hFFFF_FFFF : 32'd0);

      // DIVU by zero
      set_op(OP_DIVU, 32'd5, 32'd0, 5'd1, 5'd2, 5'd3);
      cycle();
      wait_ready(n);
      set_op(OP_MFLO, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("divz_lo", o_res, MD_EN ? 32'hFFFF_FFFF : 32'd0);
      set_op(OP_MFHI, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("divz_hi", o_res, MD_EN ? 32'd5 : 32'd0);

      // MULTU 0xFFFFFFFF * 2
      set_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd1, 5'd2, 5'd3);
      cycle();
      wait_ready(n);
      set_op(OP_MFHI, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("multu_hi", o_res, MD_EN ? 32'd1 : 32'd0);
      set_op(OP_MFLO, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("multu_lo", o_res, MD_EN ? 32'hFFFF_FFFE : 32'd0);

      // stall for three cycles after an accepted ADD
      set_op(OP_ADD, 32'd20, 32'd22, 5'd1, 5'd2, 5'd7);
      cycle();
      held = o_res;
      set_op(OP_ADD, 32'd1, 32'd2, 5'd1, 5'd2, 5'd8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      chk("stall_hold_res", o_res, 32'd42);
      chk("stall_hold_valid", {31'd0, o_valid}, 32'd1);
      stall = 1'b0;
      cycle();
      chk("stall_resume", o_res, 32'd3);
      chk("stall_resume_dst", {27'd0, o_dst}, 32'd8);
      chk("stall_prev", held, 32'd42);

      // reset in the middle of a divide
      set_op(OP_DIV, 32'd100, 32'd7, 5'd1, 5'd2, 5'd3);
      cycle();
      valid = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_mid_alures", o_res, 32'd0);
      chk("rst_mid_rt", o_rt, 32'd0);
      chk("rst_mid_dst", {27'd0, o_dst}, 32'd0);
      model_reset();
      #1 rst = 1'b0;
      set_op(OP_MFHI, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4);
      cycle();
      chk("rst_mid_ready", {31'd0, last_ready}, 32'd1);
      chk("rst_mid_mfhi", o_res, 32'd0);
      cycle();
      chk("rst_mid_mflo_dst", {27'd0, o_dst}, 32'd4);

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         valid   = ($urandom_range(0, 3) != 0);
         stall   = ($urandom_range(0, 4) == 0);
         op      = 4'($urandom_range(0, 15));
         drs     = rnd_val();
         drt     = rnd_val();
         dimm    = rnd_val();
         con_imm = 1'($urandom_range(0, 1));
         ars     = 5'($urandom_range(0, 3));
         art     = 5'($urandom_range(0, 3));
         adst    = 5'($urandom_range(0, 31));
         for (int k = 0; k < NFWD; k++) begin
            fwd_we[k]          = 1'($urandom_range(0, 1));
            fwd_addr[k*5 +: 5] = 5'($urandom_range(0, 3));
            fwd_data[k*32 +: 32] = rnd_val();
         end
         cycle();
      end
      idle();
      wait_ready(n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
